// File: rtl/rand_fifo_gen.sv
// rand_fifo_gen: xorshift32 words packed into WIDTH-bit entries in a prefetch FIFO.
// Optional macro RAND_STATS_EN adds delivered/stall counters.
module rand_fifo_gen #(
  parameter int          WIDTH = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] SEED  = 32'h00000001
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              SEED_WRITE,
  input  logic                     SEED_WRITE_VALID,
  input  logic                     DEQ,
  output logic [WIDTH-1:0]         RESP_READ,
  output logic                     RESP_READ_VALID,
  output logic [$clog2(DEPTH):0]   OCCUPANCY
`ifdef RAND_STATS_EN
  ,
  output logic [31:0]              STAT_DELIVERED,
  output logic [31:0]              STAT_STALLS
`endif
);
  localparam int NW = WIDTH / 32;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  function automatic logic [31:0] zmap(input logic [31:0] s);
    return s == 32'h0 ? 32'h2545F491 : s;
  endfunction

  logic [31:0]      state_q, state_d, nxt;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [WIDTH-1:0] asm_q, asm_d, entry;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             full, stall, push, pop;

  // Older words shift toward the MSBs, so the first word of an entry ends up on top.
  always_comb begin
    nxt     = step(state_q);
    entry   = WIDTH'({asm_q, nxt});
    full    = occ_q == FULL;
    stall   = wcnt_q == LAST && full;
    push    = wcnt_q == LAST && !full;
    pop     = DEQ && occ_q != '0;
    state_d = SEED_WRITE_VALID ? zmap(SEED_WRITE) : stall ? state_q : nxt;
    wcnt_d  = SEED_WRITE_VALID || push ? '0 : stall ? wcnt_q : wcnt_q + CW'(1);
    asm_d   = SEED_WRITE_VALID ? '0 : stall || push ? asm_q : entry;
    rd_d    = SEED_WRITE_VALID ? '0 : rd_q + AW'(pop);
    wr_d    = SEED_WRITE_VALID ? '0 : wr_q + AW'(push);
    occ_d   = SEED_WRITE_VALID ? '0 : occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
    mem_d   = mem_q;
    if (push) mem_d[wr_q] = entry;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= zmap(SEED);
      wcnt_q  <= '0;
      asm_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      asm_q   <= asm_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      occ_q   <= occ_d;
      mem_q   <= mem_d;
    end
  end

  assign RESP_READ_VALID = occ_q != '0;
  assign RESP_READ       = RESP_READ_VALID ? mem_q[rd_q] : '0;
  assign OCCUPANCY       = occ_q;

`ifdef RAND_STATS_EN
  logic [31:0] dlv_q, dlv_d, stl_q, stl_d;

  always_comb begin
    dlv_d = SEED_WRITE_VALID ? '0 : dlv_q + 32'(pop);
    stl_d = SEED_WRITE_VALID ? '0 : stall && !(&stl_q) ? stl_q + 32'd1 : stl_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dlv_q <= '0;
      stl_q <= '0;
    end else begin
      dlv_q <= dlv_d;
      stl_q <= stl_d;
    end
  end

  assign STAT_DELIVERED = dlv_q;
  assign STAT_STALLS    = stl_q;
`endif
endmodule

// File: tb/tb_rand_fifo_gen.sv
// tb_rand_fifo_gen: directed checks of rand_fifo_gen at WIDTH 32/64/96 sharing clock, reset and seed inputs.
module tb_rand_fifo_gen;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic [31:0] seed_w = '0;
  logic        seed_v = 1'b0, deq32 = 1'b0, deq64 = 1'b0, deq96 = 1'b0;
  logic [31:0] r32;
  logic [63:0] r64;
  logic [95:0] r96;
  logic        v32, v64, v96;
  logic [2:0]  o32, o64, o96;
  logic [31:0] d32, s32, d64, s64, d96, s96;
  int tests = 0, fails = 0;

  always #5 CLK = ~CLK;

  rand_fifo_gen #(.WIDTH(32), .DEPTH(4), .SEED(32'h1)) u32 (
    .CLK(CLK), .RESET(RESET), .SEED_WRITE(seed_w), .SEED_WRITE_VALID(seed_v), .DEQ(deq32),
    .RESP_READ(r32), .RESP_READ_VALID(v32), .OCCUPANCY(o32)
`ifdef RAND_STATS_EN
    , .STAT_DELIVERED(d32), .STAT_STALLS(s32)
`endif
  );
  rand_fifo_gen #(.WIDTH(64), .DEPTH(4), .SEED(32'h1)) u64 (
    .CLK(CLK), .RESET(RESET), .SEED_WRITE(seed_w), .SEED_WRITE_VALID(seed_v), .DEQ(deq64),
    .RESP_READ(r64), .RESP_READ_VALID(v64), .OCCUPANCY(o64)
`ifdef RAND_STATS_EN
    , .STAT_DELIVERED(d64), .STAT_STALLS(s64)
`endif
  );
  rand_fifo_gen #(.WIDTH(96), .DEPTH(4), .SEED(32'h1)) u96 (
    .CLK(CLK), .RESET(RESET), .SEED_WRITE(seed_w), .SEED_WRITE_VALID(seed_v), .DEQ(deq96),
    .RESP_READ(r96), .RESP_READ_VALID(v96), .OCCUPANCY(o96)
`ifdef RAND_STATS_EN
    , .STAT_DELIVERED(d96), .STAT_STALLS(s96)
`endif
  );

  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2 RESET = 1'b0;
    #1;
    tests++;
    if (r32 !== '0 || v32 !== 1'b0 || o32 !== 3'd0) begin
      fails++;
      $display("FAIL reset32: got r=%h v=%b o=%0d, want 0/0/0", r32, v32, o32);
    end
    tests++;
    if (r96 !== '0 || v96 !== 1'b0 || o96 !== 3'd0 || v64 !== 1'b0) begin
      fails++;
      $display("FAIL reset96: got r=%h v=%b o=%0d v64=%b, want zeros", r96, v96, o96, v64);
    end
    tick();
    RESET = 1'b1;
  endtask

  task automatic test_fill();
    tick();
    tests++;
    if (r32 !== 32'h00042021 || v32 !== 1'b1 || o32 !== 3'd1 || v64 !== 1'b0) begin
      fails++;
      $display("FAIL fill_edge1: got r32=%h v32=%b o32=%0d v64=%b, want 00042021/1/1/0", r32, v32, o32, v64);
    end
    tick();
    tests++;
    if (r64 !== 64'h00042021_04080601 || v64 !== 1'b1 || o64 !== 3'd1 || o32 !== 3'd2) begin
      fails++;
      $display("FAIL fill_edge2: got r64=%h o64=%0d o32=%0d, want 0004202104080601/1/2", r64, o64, o32);
    end
    tick();
    tick();
    tests++;
    if (o32 !== 3'd4 || o64 !== 3'd2) begin
      fails++;
      $display("FAIL fill_edge4: got o32=%0d o64=%0d, want 4/2", o32, o64);
    end
    tick();
    tick();
    tests++;
    if (o32 !== 3'd4 || r32 !== 32'h00042021 || o64 !== 3'd3) begin
      fails++;
      $display("FAIL fill_stall: got o32=%0d r32=%h o64=%0d, want 4/00042021/3", o32, r32, o64);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp;
    deq32 = 1'b1;
    tick();
    deq32 = 1'b0;
    tests++;
    if (r32 !== 32'h04080601 || o32 !== 3'd3) begin
      fails++;
      $display("FAIL pop_full: got r32=%h o32=%0d, want 04080601/3", r32, o32);
    end
    tick();
    tests++;
    if (o32 !== 3'd4) begin
      fails++;
      $display("FAIL refill: got o32=%0d, want 4", o32);
    end
    // Draining every cycle must show the uninterrupted xorshift stream.
    exp = 32'h04080601;
    for (int i = 0; i < 8; i++) begin
      deq32 = 1'b1;
      tests++;
      if (r32 !== exp) begin
        fails++;
        $display("FAIL stream[%0d]: got %h, want %h", i, r32, exp);
      end
      tick();
      exp = step(exp);
      tests++;
      if (o32 < 3'd3 || o32 > 3'd4) begin
        fails++;
        $display("FAIL stream_occ[%0d]: got %0d, want 3..4", i, o32);
      end
    end
    deq32 = 1'b0;
  endtask

  task automatic test_reseed();
    logic [31:0] a, b;
    a = step(32'h2545F491);
    b = step(a);
    seed_w = 32'h0;
    seed_v = 1'b1;
    deq32 = 1'b1;
    tick();
    seed_v = 1'b0;
    deq32 = 1'b0;
    tests++;
    if (v32 !== 1'b0 || o32 !== 3'd0 || r32 !== '0 || v64 !== 1'b0 || o96 !== 3'd0) begin
      fails++;
      $display("FAIL reseed_flush: got v32=%b o32=%0d r32=%h v64=%b o96=%0d, want empty", v32, o32, r32, v64, o96);
    end
    tick();
    tests++;
    if (r32 !== a || v32 !== 1'b1 || o32 !== 3'd1) begin
      fails++;
      $display("FAIL reseed_first: got r32=%h o32=%0d, want %h/1", r32, o32, a);
    end
    tick();
    tests++;
    if (r64 !== {a, b} || o64 !== 3'd1) begin
      fails++;
      $display("FAIL reseed_64: got %h o64=%0d, want %h/1", r64, o64, {a, b});
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] c;
    c = step(32'h04080601);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    tick();
    tests++;
    if (v96 !== 1'b0) begin
      fails++;
      $display("FAIL w96_early: got v96=%b, want 0", v96);
    end
    tick();
    tests++;
    if (v96 !== 1'b1 || r96 !== {32'h00042021, 32'h04080601, c}) begin
      fails++;
      $display("FAIL w96_first: got %h, want %h", r96, {32'h00042021, 32'h04080601, c});
    end
    tick();
    #2 RESET = 1'b0;
    #1;
    tests++;
    if (r96 !== '0 || v96 !== 1'b0 || o96 !== 3'd0 || r32 !== '0 || o32 !== 3'd0) begin
      fails++;
      $display("FAIL async_drop: got r96=%h o96=%0d r32=%h o32=%0d, want zeros", r96, o96, r32, o32);
    end
    tick();
    RESET = 1'b1;
    tick();
    tick();
    tick();
    tests++;
    if (r96 !== {32'h00042021, 32'h04080601, c} || o96 !== 3'd1) begin
      fails++;
      $display("FAIL async_restart: got %h o96=%0d, want %h/1", r96, o96, {32'h00042021, 32'h04080601, c});
    end
  endtask

`ifdef RAND_STATS_EN
  task automatic test_stats();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    deq96 = 1'b1;
    repeat (3) tick();
    deq96 = 1'b0;
    repeat (3) tick();
    tests++;
    if (s32 !== 32'd2) begin
      fails++;
      $display("FAIL stall_cnt: got %0d, want 2", s32);
    end
    deq32 = 1'b1;
    repeat (10) tick();
    deq32 = 1'b0;
    tests++;
    if (d32 !== 32'd10 || s32 !== 32'd3 || d96 !== 32'd0) begin
      fails++;
      $display("FAIL stats: got d32=%0d s32=%0d d96=%0d, want 10/3/0", d32, s32, d96);
    end
    seed_w = 32'h5;
    seed_v = 1'b1;
    tick();
    seed_v = 1'b0;
    tests++;
    if (d32 !== 32'd0 || s32 !== 32'd0) begin
      fails++;
      $display("FAIL stats_reseed: got d32=%0d s32=%0d, want 0/0", d32, s32);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_reseed();
    test_async_reset();
`ifdef RAND_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rand_fifo_gen.md
Name: rand_fifo_gen

Overview:
Parametrised, synthesizable pseudo-random source. It replaces the `$random`-based simulation models with an xorshift32 generator feeding a small prefetch FIFO. Each FIFO entry is WIDTH bits, built from WIDTH/32 consecutive xorshift words. Consumers pop entries with a valid/dequeue handshake and can reseed at run time; the block serves as stimulus/arbitration randomness in multi-core test harnesses.

Parameters:
WIDTH, 32, entry width; multiple of 32, range 32..128; NW = WIDTH/32
DEPTH, 4, FIFO entries; power of two, >= 2
SEED, 32'h00000001, reset seed; 0 is replaced by 32'h2545F491

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
SEED_WRITE  input  32  new seed value
SEED_WRITE_VALID  input  1  reseed strobe, one cycle
DEQ  input  1  consumer pops head entry this cycle
RESP_READ  output  WIDTH  head entry of FIFO
RESP_READ_VALID  output  1  FIFO non-empty
OCCUPANCY  output  clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (RESET=0, async):
  - state <= SEED (zero-mapped); word counter wcnt <= 0; assembly register asm <= 0
  - FIFO empty: RESP_READ_VALID=0, OCCUPANCY=0, RESP_READ=0
- Step function: x ^= x<<13; x ^= x>>17; x ^= x<<5, all 32-bit, truncated.
- Generator, each cycle not stalled:
  - state <= next = step(state)
  - if wcnt < NW-1: asm <= {asm[WIDTH-33:0], next}; wcnt++
  - if wcnt == NW-1: push {asm[WIDTH-33:0], next} into FIFO; wcnt <= 0
- Word order: the first generated word lands in the MSBs of the entry.
- Stall: wcnt == NW-1 and FIFO full at start of cycle. State, asm and wcnt hold. Words below NW-1 are never stalled.
- Push/pop:
  - A push is blocked when full, even if DEQ pops in the same cycle. Full is judged on the pre-edge occupancy.
  - DEQ with RESP_READ_VALID=0 is ignored (no underflow).
  - DEQ and push in the same non-full, non-empty cycle leave occupancy unchanged.
- RESP_READ is driven from the FIFO head. It is 0 when the FIFO is empty, combinational from registered storage only.
- Latency and throughput:
  - The first entry is visible after NW rising edges following RESET release.
  - Steady throughput is one entry per NW cycles until full.
- Reseed (SEED_WRITE_VALID=1), highest priority:
  - state <= SEED_WRITE (zero-mapped), wcnt <= 0, asm <= 0, FIFO flushed
  - Any DEQ or push in that cycle is discarded.
  - Generation resumes next cycle with an identical timeline to post-reset.
- Read/write pointers wrap modulo DEPTH. OCCUPANCY range is 0..DEPTH.

Optional Feature:
RAND_STATS_EN
- Defined:
  - Adds output STAT_DELIVERED [31:0], counting accepted DEQs (valid && DEQ). It wraps at 2^32.
  - Adds output STAT_STALLS [31:0], counting stall cycles, saturating at 32'hFFFFFFFF.
  - Both are cleared by reset and by reseed.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- WIDTH=32, SEED=1, no DEQ: release reset -> after edge 1 RESP_READ=32'h00042021, VALID=1. OCCUPANCY reaches 4 after edge 4, then holds while stalled. First DEQ exposes 32'h04080601.
- WIDTH=64, SEED=1 -> first entry 64'h00042021_04080601 valid after edge 2. OCCUPANCY increments every 2 cycles.
- Full FIFO with DEQ every cycle, WIDTH=32 -> occupancy alternates 3/4 and never exceeds DEPTH. The popped sequence is contiguous xorshift output with no skipped or duplicated words.
- SEED_WRITE=0 with SEED_WRITE_VALID, plus DEQ in the same cycle -> FIFO flushed, VALID=0 next cycle, DEQ ignored. The first new entry is step(32'h2545F491).
- Async reset asserted mid-fill (WIDTH=96, wcnt=1) with CLK idle -> outputs drop to 0 immediately. After release, the first entry matches a fresh SEED=1 run.
- RAND_STATS_EN defined: 10 accepted DEQs plus 3 DEQs while empty -> STAT_DELIVERED=10. Reseed -> both counters 0.
